// File: rtl/cdc_vga_axi_pkg.sv
// Shared types and AXI constants for the CDC VGA pattern write master.
package cdc_vga_axi_pkg;

    localparam int unsigned PIXEL_W = 16;
    localparam int unsigned MODE_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_FIN
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;

    localparam logic [MODE_W-1:0] PAT_SOLID   = 2'd0;
    localparam logic [MODE_W-1:0] PAT_INDEX   = 2'd1;
    localparam logic [MODE_W-1:0] PAT_CHECKER = 2'd2;

    // Pattern settings captured when a fill is started.
    typedef struct packed {
        logic [MODE_W-1:0]  mode;
        logic [PIXEL_W-1:0] color;
    } pat_cfg_t;

endpackage

// File: rtl/cdc_vga_pattern_gen.sv
// Combinational RGB565 test-pattern generator: two identical pixels per 32-bit word.
module cdc_vga_pattern_gen
    import cdc_vga_axi_pkg::*;
(
    input  logic [MODE_W-1:0]  mode,
    input  logic [PIXEL_W-1:0] color,
    input  logic [PIXEL_W-1:0] index,
    output logic [31:0]        wdata_c
);

    logic [PIXEL_W-1:0] pixel;

    // Checker toggles every 16 words; unknown modes fall back to solid colour.
    always_comb begin
        pixel = color;
        case (mode)
            PAT_INDEX:   pixel = index;
            PAT_CHECKER: pixel = index[4] ? ~color : color;
            default:     pixel = color;
        endcase
        wdata_c = {pixel, pixel};
    end

endmodule

// File: rtl/cdc_vga_pattern_axi_master.sv
// AXI4 write master that fills the frame buffer with a test pattern using
// fixed-length INCR bursts, one burst outstanding at a time.
module cdc_vga_pattern_axi_master
    import cdc_vga_axi_pkg::*;
#(
    parameter int unsigned                   C_M_AXI_ID_WIDTH   = 12,
    parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 17,
    parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter int unsigned                   C_BURST_LEN        = 16,
    parameter int unsigned                   C_FB_WORDS         = 32768
) (
    input  logic                            ACLK,
    input  logic                            reset_aclk,
    input  logic                            start,
    input  logic [1:0]                      pattern_sel,
    input  logic [15:0]                     fill_color,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    localparam int unsigned ADDR_W      = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DATA_W      = C_M_AXI_DATA_WIDTH;
    localparam int unsigned WORD_W      = $clog2(C_FB_WORDS + 1);
    localparam int unsigned BURSTS      = C_FB_WORDS / C_BURST_LEN;
    localparam int unsigned BURST_W     = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int unsigned BEAT_W      = (C_BURST_LEN > 1) ? $clog2(C_BURST_LEN) : 1;
    localparam int unsigned BURST_BYTES = C_BURST_LEN * 4;

    state_t              state;
    state_t              state_nxt;
    pat_cfg_t            cfg;
    logic [BURST_W-1:0]  burst_idx;
    logic [WORD_W-1:0]   word_idx;
    logic [BEAT_W-1:0]   beat;

    logic                aw_hs_c;
    logic                w_hs_c;
    logic                b_hs_c;
    logic                fb_end_c;
    logic [WORD_W-1:0]   word_idx_nxt_c;
    logic [31:0]         wdata_c;

    // Unused write-address sideband is tied off.
    assign M_AXI_AWID   = '0;
    assign M_AXI_AWLOCK = 1'b0;
    assign M_AXI_AWPROT = '0;
    assign M_AXI_AWQOS  = '0;

    // Pattern word for the beat that will be presented next.
    cdc_vga_pattern_gen u_pattern_gen (
        .mode    (cfg.mode),
        .color   (cfg.color),
        .index   (16'(word_idx_nxt_c)),
        .wdata_c (wdata_c)
    );

    // Next-state logic.
    always_comb begin
        state_nxt      = state;
        aw_hs_c        = M_AXI_AWVALID & M_AXI_AWREADY;
        w_hs_c         = M_AXI_WVALID & M_AXI_WREADY;
        b_hs_c         = M_AXI_BREADY & M_AXI_BVALID;
        fb_end_c       = (word_idx == WORD_W'(C_FB_WORDS));
        word_idx_nxt_c = word_idx + WORD_W'(w_hs_c);
        case (state)
            ST_IDLE: if (start)                  state_nxt = ST_ADDR;
            ST_ADDR: if (aw_hs_c)                state_nxt = ST_DATA;
            ST_DATA: if (w_hs_c && M_AXI_WLAST)  state_nxt = ST_RESP;
            ST_RESP: if (b_hs_c)                 state_nxt = fb_end_c ? ST_FIN : ST_ADDR;
            ST_FIN:                              state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (reset_aclk) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Counters and AXI channel registers; payloads only change on handshakes.
    always_ff @(posedge ACLK) begin
        if (reset_aclk) begin
            cfg           <= '0;
            burst_idx     <= '0;
            word_idx      <= '0;
            beat          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWLEN   <= '0;
            M_AXI_AWSIZE  <= '0;
            M_AXI_AWBURST <= '0;
            M_AXI_AWCACHE <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WLAST   <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cfg           <= '{mode: pattern_sel, color: fill_color};
                        burst_idx     <= '0;
                        word_idx      <= '0;
                        beat          <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        M_AXI_AWADDR  <= C_BASE_ADDR;
                        M_AXI_AWLEN   <= 8'(C_BURST_LEN - 1);
                        M_AXI_AWSIZE  <= AXI_SIZE_4B;
                        M_AXI_AWBURST <= AXI_BURST_INCR;
                        M_AXI_AWCACHE <= AXI_CACHE_BUF_MOD;
                        M_AXI_AWVALID <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (aw_hs_c) begin
                        M_AXI_AWVALID <= 1'b0;
                        M_AXI_WVALID  <= 1'b1;
                        M_AXI_WSTRB   <= '1;
                        M_AXI_WDATA   <= DATA_W'(wdata_c);
                        M_AXI_WLAST   <= (C_BURST_LEN == 1);
                        beat          <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_hs_c) begin
                        word_idx <= word_idx_nxt_c;
                        if (M_AXI_WLAST) begin
                            M_AXI_WVALID <= 1'b0;
                            M_AXI_WLAST  <= 1'b0;
                            M_AXI_BREADY <= 1'b1;
                        end else begin
                            beat        <= beat + BEAT_W'(1);
                            M_AXI_WDATA <= DATA_W'(wdata_c);
                            M_AXI_WLAST <= ((beat + BEAT_W'(1)) == BEAT_W'(C_BURST_LEN - 1));
                        end
                    end
                end
                ST_RESP: begin
                    if (b_hs_c) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP != AXI_RESP_OKAY) error <= 1'b1;
                        if (fb_end_c) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            burst_idx     <= burst_idx + BURST_W'(1);
                            M_AXI_AWADDR  <= C_BASE_ADDR
                                           + ADDR_W'(burst_idx + BURST_W'(1)) * ADDR_W'(BURST_BYTES);
                            M_AXI_AWVALID <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_vga_pattern_axi_master.sv
// Scoreboard bench for the pattern write master: stimulus queues expectations,
// a negedge monitor compares every handshake and status probe.
module tb_cdc_vga_pattern_axi_master;

    localparam int unsigned BURST_LEN = 16;
    localparam int unsigned FB_WORDS  = 64;
    localparam int unsigned BURSTS    = FB_WORDS / BURST_LEN;
    localparam logic [16:0] BASE      = 17'h0;

    typedef enum {K_STATUS, K_RESET_PAYLOAD, K_TIMEOUT, K_FLUSH, K_DRAIN} kind_e;
    typedef struct {
        kind_e      kind;
        string      name;
        logic [5:0] flags;   // {busy, done, error, awvalid, wvalid, bready}
    } item_t;
    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        ACLK = 1'b0;
    logic        reset_aclk;
    logic        start;
    logic [1:0]  pattern_sel;
    logic [15:0] fill_color;
    logic        busy, done, error;
    logic [11:0] M_AXI_AWID;
    logic [16:0] M_AXI_AWADDR;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWLOCK;
    logic [3:0]  M_AXI_AWCACHE;
    logic [2:0]  M_AXI_AWPROT;
    logic [3:0]  M_AXI_AWQOS;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;

    item_t       stat_q[$];
    logic [16:0] aw_q[$];
    beat_t       w_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        stall_en;
    logic [16:0] err_addr;

    always #5 ACLK = ~ACLK;

    cdc_vga_pattern_axi_master #(
        .C_BASE_ADDR (BASE),
        .C_BURST_LEN (BURST_LEN),
        .C_FB_WORDS  (FB_WORDS)
    ) dut (
        .ACLK          (ACLK),
        .reset_aclk    (reset_aclk),
        .start         (start),
        .pattern_sel   (pattern_sel),
        .fill_color    (fill_color),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .M_AXI_AWID    (M_AXI_AWID),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWLOCK  (M_AXI_AWLOCK),
        .M_AXI_AWCACHE (M_AXI_AWCACHE),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWQOS   (M_AXI_AWQOS),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY)
    );

    // Reference pixel function.
    function automatic logic [31:0] model_word(input logic [1:0] m, input logic [15:0] c, input int i);
        logic [15:0] iv;
        logic [15:0] p;
        iv = 16'(i);
        case (m)
            2'd1:    p = iv;
            2'd2:    p = iv[4] ? ~c : c;
            default: p = c;
        endcase
        return {p, p};
    endfunction

    function automatic void push_item(input kind_e k, input string name, input logic [5:0] f);
        item_t it;
        it.kind  = k;
        it.name  = name;
        it.flags = f;
        stat_q.push_back(it);
    endfunction

    function automatic void expect_fill(input logic [1:0] m, input logic [15:0] c);
        beat_t b;
        for (int k = 0; k < int'(BURSTS); k++) aw_q.push_back(BASE + 17'(k * BURST_LEN * 4));
        for (int i = 0; i < int'(FB_WORDS); i++) begin
            b.data = model_word(m, c, i);
            b.last = ((i % int'(BURST_LEN)) == int'(BURST_LEN) - 1);
            w_q.push_back(b);
        end
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Slave model: random READY/BVALID stalls, error response for err_addr.
    initial begin : slave
        logic        rst_s, wl_hs, b_hs;
        logic [16:0] cur_addr;
        int          b_pend;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        b_pend        = 0;
        cur_addr      = '0;
        forever begin
            @(negedge ACLK);
            rst_s = reset_aclk;
            wl_hs = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST;
            b_hs  = M_AXI_BVALID && M_AXI_BREADY;
            if (M_AXI_AWVALID && M_AXI_AWREADY) cur_addr = M_AXI_AWADDR;
            @(posedge ACLK);
            #2;
            if (rst_s) begin
                b_pend       = 0;
                M_AXI_BVALID = 1'b0;
                M_AXI_BRESP  = 2'b00;
            end else begin
                if (wl_hs) b_pend++;
                if (b_hs) begin
                    M_AXI_BVALID = 1'b0;
                    M_AXI_BRESP  = 2'b00;
                end
                if (!M_AXI_BVALID && b_pend > 0 && (!stall_en || $urandom_range(0, 2) == 0)) begin
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP  = (cur_addr == err_addr) ? 2'b10 : 2'b00;
                    b_pend--;
                end
            end
            M_AXI_AWREADY = !stall_en || ($urandom_range(0, 3) != 0);
            M_AXI_WREADY  = !stall_en || ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: status probes, handshake scoreboard, stall stability, AW/W exclusivity.
    logic        aw_hold = 1'b0, w_hold = 1'b0;
    logic [63:0] aw_prev = '0, w_prev = '0;
    always @(negedge ACLK) begin : monitor
        item_t       it;
        logic [16:0] ea;
        beat_t       eb;
        logic [63:0] aw_act, w_act, aw_pay;
        aw_pay = 64'({M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
                      M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS});
        aw_act = 64'({M_AXI_AWVALID, aw_pay[54:0]});
        w_act  = 64'({M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST});
        while (stat_q.size() != 0) begin
            it = stat_q.pop_front();
            case (it.kind)
                K_STATUS: check(it.name, 64'({busy, done, error, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}),
                                64'(it.flags));
                K_RESET_PAYLOAD: begin
                    check("reset_aw_payload", aw_pay, 64'(0));
                    check("reset_w_payload", 64'({M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST}), 64'(0));
                end
                K_TIMEOUT: begin
                    checks++;
                    errors++;
                    $display("FAIL %s: timed out waiting for the DUT", it.name);
                end
                K_FLUSH: begin
                    aw_q.delete();
                    w_q.delete();
                end
                default: begin
                    check("drain_aw", 64'(aw_q.size()), 64'(0));
                    check("drain_w", 64'(w_q.size()), 64'(0));
                end
            endcase
        end
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            if (aw_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL aw_extra: got addr %h expected no burst", M_AXI_AWADDR);
            end else begin
                ea = aw_q.pop_front();
                check("aw_burst", aw_pay,
                      64'({12'h0, ea, 8'(BURST_LEN - 1), 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0}));
            end
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
            if (w_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w_extra: got data %h expected no beat", M_AXI_WDATA);
            end else begin
                eb = w_q.pop_front();
                check("w_beat", 64'({M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST}), 64'({eb.data, 4'hF, eb.last}));
            end
        end
        if (aw_hold) check("aw_stable", aw_act, aw_prev);
        if (w_hold)  check("w_stable", w_act, w_prev);
        if (M_AXI_AWVALID || M_AXI_WVALID)
            check("aw_w_overlap", 64'(M_AXI_AWVALID && M_AXI_WVALID), 64'(0));
        aw_hold = !reset_aclk && M_AXI_AWVALID && !M_AXI_AWREADY;
        w_hold  = !reset_aclk && M_AXI_WVALID && !M_AXI_WREADY;
        aw_prev = aw_act;
        w_prev  = w_act;
    end

    // Called at posedge+1; accepted at the next edge, probed right after it.
    task automatic do_start(input logic [1:0] m, input logic [15:0] c);
        pattern_sel = m;
        fill_color  = c;
        start       = 1'b1;
        expect_fill(m, c);
        @(posedge ACLK);
        #1;
        start = 1'b0;
        push_item(K_STATUS, "start_ack", 6'b100100);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge ACLK);
            #1;
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) push_item(K_TIMEOUT, name, 6'b0);
    endtask

    initial begin : stimulus
        bit found;
        reset_aclk  = 1'b1;
        start       = 1'b0;
        pattern_sel = 2'd0;
        fill_color  = 16'h0;
        stall_en    = 1'b0;
        err_addr    = 17'h1FFFF;
        repeat (3) @(posedge ACLK);
        #1;
        push_item(K_STATUS, "reset_ctl", 6'b000000);
        push_item(K_RESET_PAYLOAD, "reset_payload", 6'b0);
        reset_aclk = 1'b0;
        @(posedge ACLK);
        #1;

        // Index pattern, always-ready slave: done exactly 72 cycles after accept.
        do_start(2'd1, 16'h0);
        repeat (71) begin
            @(posedge ACLK);
            #1;
        end
        push_item(K_STATUS, "cycle71_wait_b", 6'b100001);
        @(posedge ACLK);
        #1;
        push_item(K_STATUS, "cycle72_done", 6'b010000);
        repeat (2) @(posedge ACLK);
        #1;

        // Same fill with random stalls on every channel.
        stall_en = 1'b1;
        do_start(2'd1, 16'h0);
        wait_done("done_stall", 3000);
        push_item(K_STATUS, "fin_stall", 6'b010000);
        stall_en = 1'b0;
        @(posedge ACLK);
        #1;

        // SLVERR on burst 1: remaining bursts still issued, error sticky.
        err_addr = 17'h00040;
        do_start(2'd1, 16'h0);
        wait_done("done_err", 500);
        push_item(K_STATUS, "fin_err", 6'b011000);
        @(posedge ACLK);
        #1;
        err_addr = 17'h1FFFF;
        do_start(2'd0, 16'hABCD);
        wait_done("done_clean", 500);
        push_item(K_STATUS, "fin_clean", 6'b010000);
        @(posedge ACLK);
        #1;

        // Checker and the reserved mode code.
        do_start(2'd2, 16'hF800);
        wait_done("done_checker", 500);
        @(posedge ACLK);
        #1;
        do_start(2'd3, 16'h1234);
        wait_done("done_mode3", 500);
        @(posedge ACLK);
        #1;

        // start during DATA and during the FIN cycle must both be ignored.
        do_start(2'd0, 16'h5A5A);
        found = 0;
        for (int c = 0; c < 50; c++) begin
            if (M_AXI_WVALID) begin
                found = 1;
                break;
            end
            @(posedge ACLK);
            #1;
        end
        if (!found) push_item(K_TIMEOUT, "wait_wvalid", 6'b0);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        push_item(K_STATUS, "start_in_data", 6'b100010);
        wait_done("done_pulse", 500);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
        push_item(K_STATUS, "start_at_fin", 6'b010000);
        @(posedge ACLK);
        #1;
        push_item(K_STATUS, "idle_after_fin", 6'b010000);

        // Reset at beat 7 of burst 2, then a full restart from the base address.
        do_start(2'd1, 16'h0);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (M_AXI_WVALID && M_AXI_WDATA == 32'h0027_0027) begin
                found = 1;
                break;
            end
            @(posedge ACLK);
            #1;
        end
        if (!found) push_item(K_TIMEOUT, "wait_beat39", 6'b0);
        reset_aclk = 1'b1;
        @(posedge ACLK);
        #1;
        reset_aclk = 1'b0;
        push_item(K_STATUS, "after_reset", 6'b000000);
        push_item(K_FLUSH, "flush", 6'b0);
        @(posedge ACLK);
        #1;
        do_start(2'd1, 16'h0);
        wait_done("done_after_reset", 500);
        push_item(K_STATUS, "fin_after_reset", 6'b010000);
        push_item(K_DRAIN, "drain", 6'b0);
        repeat (3) @(posedge ACLK);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
